mulacc: RTL

Sequential shift-add multiply-accumulator: computes `prod = a*b + c` over `WIDTH`-bit unsigned operands, one multiplier bit per cycle, with early termination. It is the inverse of the divider: feeding it `quot`, `den`, `rem` reconstructs `num`. It uses the same `go`/`ready`/`error` handshake so that the prime-generator datapath and benches drive both blocks identically.

---
 rtl/mulacc_pkg.sv | 12 +
 rtl/mulacc_if.sv | 17 +
 rtl/mulacc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mulacc_pkg.sv
// Shared arithmetic constants: FSM encoding common to the multiplier and divider.
package mulacc_pkg;

  localparam int MULACC_WIDTH_LOG = 4;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/mulacc_if.sv
// go/ready/error handshake bundle for the multiply-accumulator.
interface mulacc_if
  import mulacc_pkg::*;
#(
  parameter int WIDTH = 1 << MULACC_WIDTH_LOG
);
  logic             go;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ready;
  logic             error;
  logic [WIDTH-1:0] prod;

  modport master (output go, a, b, c, input  ready, error, prod);
  modport slave  (input  go, a, b, c, output ready, error, prod);
endinterface

// File: rtl/mulacc.sv
// Sequential shift-add multiply-accumulate: prod = a*b + c, one multiplier bit per
// cycle, stopping as soon as the remaining multiplier bits are all zero.
module mulacc
  import mulacc_pkg::*;
#(
  parameter int WIDTH_LOG = MULACC_WIDTH_LOG
) (
  input logic     clk,
  input logic     rst,
  mulacc_if.slave bus
);
  localparam int WIDTH = 1 << WIDTH_LOG;

  state_t           st, st_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic             ovf, ovf_n;
  logic             big, big_n;
  logic             ready_q, error_q;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= ST_READY;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      ovf     <= 1'b0;
      big     <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      st      <= st_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      ovf     <= ovf_n;
      big     <= big_n;
      ready_q <= (st_n != ST_BUSY);
      error_q <= (st_n == ST_ERROR);
    end
  end

  assign addend = mplier[0] ? mcand : '0;
  assign sum    = {1'b0, acc} + {1'b0, addend};

  always_comb begin
    st_n     = st;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    ovf_n    = ovf;
    big_n    = big;
    case (st)
      ST_BUSY: begin
        // big only matters once it is actually added in, so a high multiplicand
        // bit later multiplied by zero never flags overflow.
        if (mplier[0]) begin
          acc_n = sum[WIDTH-1:0];
          ovf_n = ovf | sum[WIDTH] | big;
        end
        mcand_n  = mcand << 1;
        big_n    = big | mcand[WIDTH-1];
        mplier_n = mplier >> 1;
        if (mplier_n == '0) st_n = ovf_n ? ST_ERROR : ST_READY;
      end
      ST_READY, ST_ERROR: begin
        if (bus.go) begin
          acc_n    = bus.c;
          mcand_n  = bus.a;
          mplier_n = bus.b;
          ovf_n    = 1'b0;
          big_n    = 1'b0;
          st_n     = ST_BUSY;
        end
      end
      default: st_n = ST_READY;
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.error = error_q;
  assign bus.prod  = acc;

`ifdef SIM
  localparam int FW = 2 * WIDTH + 1;
  logic [WIDTH-1:0] la, lb, lc;
  logic             ready_d;
  logic [FW-1:0]    full;

  assign full = FW'(la) * FW'(lb) + FW'(lc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      la      <= '0;
      lb      <= '0;
      lc      <= '0;
      ready_d <= 1'b1;
    end else begin
      ready_d <= ready_q;
      if (st != ST_BUSY && bus.go) begin
        la <= bus.a;
        lb <= bus.b;
        lc <= bus.c;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (st != ST_BUSY && bus.go)
        assert (!$isunknown({bus.a, bus.b, bus.c})) else $error("operand X at accept");
      assert (!$isunknown({ready_q, error_q, acc})) else $error("output X");
      if (ready_q && !ready_d) begin
        assert (acc == full[WIDTH-1:0]) else $error("prod wrong");
        assert (error_q == (full >= FW'(1) << WIDTH)) else $error("error flag wrong");
      end
    end
  end
`endif

endmodule
